// File: rtl/fault_campaign_ctrl.sv
// Fault-campaign controller: runs back-to-back experiments, injects one
// random fault per run, classifies the outcome and resets the target DUT.
module fault_campaign_ctrl #(
  parameter int          WIDTH      = 32,
  parameter int          NCH        = 7,
  parameter int          DELAY_W    = 12,
  parameter int          TIMEOUT    = 102400,
  parameter int          NEXP       = 10,
  parameter int          RST_CYCLES = 3,
  parameter logic [31:0] SEED       = 32'h1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [8:0]               cfg_prob,
  input  logic [1:0]               cfg_mode,
  input  logic                     trigger,
  input  logic                     done,
  output logic                     dut_rst,
  output logic                     inj_valid,
  output logic [$clog2(NCH)-1:0]   inj_chan,
  output logic [WIDTH-1:0]         inj_mask,
  output logic [1:0]               inj_mode,
  output logic                     result_valid,
  output logic [1:0]               result_code,
  output logic [15:0]              exp_count,
  output logic                     busy,
  output logic                     campaign_done
);

  localparam int CW = $clog2(NCH);
  localparam int BW = $clog2(WIDTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(RST_CYCLES + 1);

  localparam logic [31:0]   TAPS     = 32'h8020_0003;
  localparam logic [31:0]   SEED_I   = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [CW:0]   NCH_X    = (CW+1)'(NCH);
  localparam logic [CW-1:0] NCH_C    = CW'(NCH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
  localparam logic [15:0]   NEXP_C   = 16'(NEXP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_DELAY,
    S_INJECT,
    S_RUN,
    S_DUTRST,
    S_FINISH
  } state_t;

  state_t              r_state;
  logic [31:0]         r_lfsr;
  logic [DELAY_W-1:0]  r_dly;
  logic [DELAY_W-1:0]  r_dcnt;
  logic [BW-1:0]       r_bit;
  logic [CW-1:0]       r_chan;
  logic                r_inj_en;
  logic                r_injected;
  logic                r_trig_ok;
  logic [TW-1:0]       r_tmo;
  logic [RW-1:0]       r_rcnt;

  logic [31:0]         w_lfsr_nxt;
  logic [7:0]          w_p;
  logic [DELAY_W-1:0]  w_dly;
  logic [BW-1:0]       w_bit;
  logic [CW-1:0]       w_raw;
  logic [CW-1:0]       w_chan;
  logic [WIDTH-1:0]    w_mask;
  logic                w_grp;
  logic                w_tmo;
  logic                w_end;
  logic                w_dexit;
  logic [1:0]          w_code;

  assign w_lfsr_nxt = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? TAPS : 32'h0);

  assign w_p    = r_lfsr[7:0];
  assign w_dly  = r_lfsr[8 +: DELAY_W];
  assign w_bit  = r_lfsr[24 +: BW];
  assign w_raw  = r_lfsr[31 -: CW];
  assign w_chan = ({1'b0, w_raw} < NCH_X) ? w_raw : (w_raw - NCH_C);

  assign w_mask = (inj_mode == 2'b11) ? '1 : (WIDTH'(1) << r_bit);

  assign w_grp   = (r_state == S_DELAY) || (r_state == S_INJECT) ||
                   (r_state == S_RUN);
  assign w_tmo   = (r_tmo == TMO_LAST);
  assign w_end   = w_grp && (done || w_tmo);
  // A zero delay still spends one cycle in DELAY.
  assign w_dexit = (r_dly == '0) || (r_dcnt == r_dly - DELAY_W'(1));
  assign w_code  = done ? {1'b0, r_injected} : 2'b10;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_lfsr        <= SEED_I;
      r_dly         <= '0;
      r_dcnt        <= '0;
      r_bit         <= '0;
      r_chan        <= '0;
      r_inj_en      <= 1'b0;
      r_injected    <= 1'b0;
      r_trig_ok     <= 1'b0;
      r_tmo         <= '0;
      r_rcnt        <= '0;
      dut_rst       <= 1'b1;
      inj_valid     <= 1'b0;
      inj_chan      <= '0;
      inj_mask      <= '0;
      inj_mode      <= 2'b00;
      result_valid  <= 1'b0;
      result_code   <= 2'b00;
      exp_count     <= '0;
      busy          <= 1'b0;
      campaign_done <= 1'b0;
    end else begin
      r_lfsr       <= w_lfsr_nxt;
      inj_valid    <= 1'b0;
      result_valid <= 1'b0;
      if (w_grp) r_tmo <= r_tmo + TW'(1);

      unique case (r_state)
        S_IDLE, S_FINISH: begin
          if (start) begin
            r_state       <= S_ARMED;
            exp_count     <= '0;
            dut_rst       <= 1'b0;
            busy          <= 1'b1;
            campaign_done <= 1'b0;
            r_trig_ok     <= 1'b1;
          end
        end
        S_ARMED: begin
          if (trigger && r_trig_ok) begin
            r_state    <= S_DELAY;
            r_dly      <= w_dly;
            r_dcnt     <= '0;
            r_bit      <= w_bit;
            r_chan     <= w_chan;
            r_inj_en   <= ({1'b0, w_p} < cfg_prob);
            r_injected <= 1'b0;
            r_tmo      <= '0;
            inj_mode   <= cfg_mode;
          end else if (!trigger) begin
            r_trig_ok <= 1'b1;
          end
        end
        S_DELAY: begin
          if (!w_end) begin
            if (w_dexit) begin
              if (r_inj_en) begin
                r_state    <= S_INJECT;
                inj_valid  <= 1'b1;
                inj_chan   <= r_chan;
                inj_mask   <= w_mask;
                r_injected <= 1'b1;
              end else begin
                r_state <= S_RUN;
              end
            end else begin
              r_dcnt <= r_dcnt + DELAY_W'(1);
            end
          end
        end
        S_INJECT: begin
          if (!w_end) r_state <= S_RUN;
        end
        S_RUN: begin
        end
        S_DUTRST: begin
          if (!trigger) r_trig_ok <= 1'b1;
          if (r_rcnt == RST_LAST) begin
            if (exp_count == NEXP_C) begin
              r_state       <= S_FINISH;
              campaign_done <= 1'b1;
              busy          <= 1'b0;
            end else begin
              r_state <= S_ARMED;
              dut_rst <= 1'b0;
            end
          end else begin
            r_rcnt <= r_rcnt + RW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Leaving the DELAY/INJECT/RUN group: report and reset the DUT.
      if (w_end) begin
        r_state      <= S_DUTRST;
        result_valid <= 1'b1;
        result_code  <= w_code;
        exp_count    <= exp_count + 16'd1;
        dut_rst      <= 1'b1;
        r_rcnt       <= '0;
        r_trig_ok    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// Directed bench for fault_campaign_ctrl with an LFSR reference model
// and queued expectations for injection and result strobes.
module tb_fault_campaign_ctrl;

  localparam int NCH     = 7;
  localparam int WIDTH   = 32;
  localparam int DELAY_W = 6;
  localparam int TMO     = 200;
  localparam int NEXP    = 3;
  localparam int RSTC    = 3;

  typedef struct {
    int          cyc;
    logic [2:0]  chan;
    logic [31:0] mask;
    logic [1:0]  mode;
  } inj_e_t;

  typedef struct {
    int         cyc;
    logic [1:0] code;
  } res_e_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  cfg_prob = '0;
  logic [1:0]  cfg_mode = '0;
  logic        trigger = 1'b0;
  logic        done = 1'b0;
  logic        dut_rst;
  logic        inj_valid;
  logic [2:0]  inj_chan;
  logic [31:0] inj_mask;
  logic [1:0]  inj_mode;
  logic        result_valid;
  logic [1:0]  result_code;
  logic [15:0] exp_count;
  logic        busy;
  logic        campaign_done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int m_exp   = 0;
  logic [31:0] m_lfsr;
  inj_e_t inj_q[$];
  res_e_t res_q[$];
  inj_e_t m_ie;
  res_e_t m_re;

  always #5 clk = ~clk;

  fault_campaign_ctrl #(
    .WIDTH(WIDTH), .NCH(NCH), .DELAY_W(DELAY_W), .TIMEOUT(TMO),
    .NEXP(NEXP), .RST_CYCLES(RSTC), .SEED(32'h1)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_prob(cfg_prob), .cfg_mode(cfg_mode),
    .trigger(trigger), .done(done),
    .dut_rst(dut_rst), .inj_valid(inj_valid),
    .inj_chan(inj_chan), .inj_mask(inj_mask), .inj_mode(inj_mode),
    .result_valid(result_valid), .result_code(result_code),
    .exp_count(exp_count), .busy(busy), .campaign_done(campaign_done)
  );

  // Reference Galois LFSR and cycle counter.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) m_lfsr <= 32'h1;
    else m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 32'h8020_0003 : 32'h0);
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_dut_rst"}, dut_rst, 1);
    chk({tag, "_inj_valid"}, inj_valid, 0);
    chk({tag, "_inj_chan"}, inj_chan, 0);
    chk({tag, "_inj_mask"}, inj_mask, 0);
    chk({tag, "_inj_mode"}, inj_mode, 0);
    chk({tag, "_res_valid"}, result_valid, 0);
    chk({tag, "_res_code"}, result_code, 0);
    chk({tag, "_exp_count"}, exp_count, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_camp_done"}, campaign_done, 0);
  endtask

  // Scoreboard: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && inj_valid) begin
      if (inj_q.size() == 0) chk("inj_spurious", inj_valid, 0);
      else begin
        m_ie = inj_q.pop_front();
        chk("inj_cyc", cyc, m_ie.cyc);
        chk("inj_chan", inj_chan, m_ie.chan);
        chk("inj_mask", inj_mask, m_ie.mask);
        chk("inj_mode", inj_mode, m_ie.mode);
        chk("inj_chan_range", inj_chan < 3'(NCH), 1);
      end
    end
    if (!rst && result_valid) begin
      if (res_q.size() == 0) chk("res_spurious", result_valid, 0);
      else begin
        m_re = res_q.pop_front();
        chk("res_cyc", cyc, m_re.cyc);
        chk("res_code", result_code, m_re.code);
      end
    end
  end

  task automatic start_campaign();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_exp = 0;
    chk("start_busy", busy, 1);
    chk("start_exp_clr", exp_count, 0);
    chk("start_dut_rst", dut_rst, 0);
    chk("start_camp_done", campaign_done, 0);
  endtask

  // kd: cycle after trigger at which done is seen (0 = never, -2 = dly+1).
  // rst_at: cycle to assert rst instead of finishing (-1 = dly+10).
  task automatic run_exp(input int kd, input bit keep_trig, input bit held,
                         input int start_at, input int rst_at);
    int g, d, e, k, c0, kde, rse;
    bit inj_en, timed, inj;
    logic [2:0] raw;
    inj_e_t ie;
    res_e_t re;
    g = 0;
    while (dut_rst === 1'b1 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    chk("arm_wait", dut_rst, 0);
    if (held) begin
      repeat (10) @(negedge clk);
      trigger = 1'b0;
    end
    repeat (2) @(negedge clk);
    trigger = 1'b1;
    c0 = cyc;
    d = int'(m_lfsr[8 +: DELAY_W]);
    if (d == 0) d = 1;
    kde = (kd == -2) ? d + 1 : kd;
    rse = (rst_at == -1) ? d + 10 : rst_at;
    inj_en = ({1'b0, m_lfsr[7:0]} < cfg_prob);
    if (kde > 0 && kde <= TMO) begin
      e = kde;
      timed = 1'b0;
    end else begin
      e = TMO;
      timed = 1'b1;
    end
    inj = inj_en && (e > d);
    raw = m_lfsr[31:29];
    if (inj) begin
      ie.cyc  = c0 + d + 1;
      ie.chan = (raw < 3'(NCH)) ? raw : raw - 3'(NCH);
      ie.mask = (cfg_mode == 2'b11) ? 32'hFFFF_FFFF
                                    : (32'h1 << m_lfsr[28:24]);
      ie.mode = cfg_mode;
      inj_q.push_back(ie);
    end
    re.cyc  = c0 + e + 1;
    re.code = timed ? 2'b10 : (inj ? 2'b01 : 2'b00);
    res_q.push_back(re);
    for (k = 1; k <= e; k++) begin
      @(negedge clk);
      if (k == 1) chk("run_busy", busy, 1);
      start = (k == start_at);
      if (k == kde) done = 1'b1;
      if (k == rse) begin
        rst = 1'b1;
        @(negedge clk);
        chk_reset("mid_rst");
        rst = 1'b0;
        start = 1'b0;
        done = 1'b0;
        trigger = 1'b0;
        res_q.delete();
        return;
      end
    end
    @(negedge clk);
    start = 1'b0;
    m_exp++;
    chk("exp_count", exp_count, m_exp);
    chk("dut_rst_pulse0", dut_rst, 1);
    if (!keep_trig) trigger = 1'b0;
    done = 1'b0;
    repeat (RSTC - 1) begin
      @(negedge clk);
      chk("dut_rst_pulse", dut_rst, 1);
    end
    @(negedge clk);
    chk("dut_rst_after", dut_rst, m_exp == NEXP);
    chk("campaign_done", campaign_done, m_exp == NEXP);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset("por");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_dut_rst", dut_rst, 1);
    chk("idle_busy", busy, 0);

    // Never inject: clean results only.
    cfg_prob = 9'd0;
    cfg_mode = 2'b00;
    start_campaign();
    repeat (3) run_exp(50, 1'b0, 1'b0, 0, 0);
    chk("finA_busy", busy, 0);
    chk("finA_exp_count", exp_count, 3);

    // Always inject bit flips: late done, early done, done during INJECT.
    cfg_prob = 9'd256;
    cfg_mode = 2'b00;
    start_campaign();
    run_exp(100, 1'b0, 1'b0, 0, 0);
    run_exp(1, 1'b0, 1'b0, 0, 0);
    run_exp(-2, 1'b0, 1'b0, 0, 0);
    chk("finB_exp_count", exp_count, 3);

    // Zero-word mode: timeout with start in RUN, held trigger, reset in RUN.
    cfg_mode = 2'b11;
    start_campaign();
    run_exp(0, 1'b1, 1'b0, 100, 0);
    run_exp(70, 1'b0, 1'b1, 0, 0);
    run_exp(0, 1'b0, 1'b0, 0, -1);
    repeat (20) @(negedge clk);
    chk("post_rst_dut_rst", dut_rst, 1);
    chk("post_rst_busy", busy, 0);
    chk("inj_q_empty", inj_q.size(), 0);
    chk("res_q_empty", res_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fault_campaign_ctrl.md
Name: fault_campaign_ctrl

Overview:
- Synthesizable, parametrised fault-campaign controller for the redundant-core SoC.
- Runs NEXP back-to-back experiments; each one optionally injects a single fault into one of NCH target channels (register/PC taps) after a random delay.
- Also watches for completion or timeout, classifies the result and resets the DUT between experiments.
- Replaces bench-only fault injection so campaigns run on FPGA.

Parameters:
- WIDTH, 32: target word width; power of two.
- NCH, 7: number of injectable channels, ≥2.
- DELAY_W, 12: random delay width; delay range 0..2^DELAY_W-1 cycles.
- TIMEOUT, 102400: cycles from trigger to declare "broken".
- NEXP, 10: experiments per campaign, 1..65535.
- RST_CYCLES, 3: DUT reset pulse length, ≥1.
- SEED, 32'h1: LFSR seed; a value of 0 is replaced by 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins a campaign from IDLE or FINISH.
- cfg_prob  in  9  injection threshold; inject iff p < cfg_prob (0 = never, 256 = always).
- cfg_mode  in  2  fault mode: 00 bit-flip, 01 stuck-at-0, 10 stuck-at-1, 11 zero word.
- trigger  in  1  DUT reports workload started (level).
- done  in  1  DUT reports workload finished (level).
- dut_rst  out  1  active-high DUT reset.
- inj_valid  out  1  one-cycle injection strobe.
- inj_chan  out  $clog2(NCH)  target channel.
- inj_mask  out  WIDTH  one-hot bit mask; all-ones when mode is 11.
- inj_mode  out  2  registered copy of cfg_mode.
- result_valid  out  1  one-cycle result strobe.
- result_code  out  2  00 clean/no fault, 01 fault injected and completed, 10 timeout (broken).
- exp_count  out  16  completed experiments.
- busy  out  1  high in every state except IDLE and FINISH.
- campaign_done  out  1  high in FINISH.

Behaviour:
- **Reset values:** while rst is high, all outputs are 0 except dut_rst=1. State goes to IDLE and the LFSR loads SEED (or 1 if SEED is 0).
- **Reset mid-operation:** aborts immediately. No result_valid is issued.
- **LFSR:** 32-bit Galois LFSR, taps 32'h80200003. Advances every cycle not in reset.
- **States:** IDLE, ARMED, DELAY, INJECT, RUN, DUTRST, FINISH.
- **IDLE:**
  - dut_rst=1.
  - start → ARMED; clear exp_count; dut_rst=0 from the next cycle.
- **ARMED:** wait for trigger=1. On that cycle, sample from the current LFSR value:
  - p = lfsr[7:0].
  - dly = lfsr[8+DELAY_W-1:8].
  - bit = lfsr[24 +: log2 WIDTH].
  - raw = lfsr[31 -: CW], where CW = $clog2(NCH).
  - chan = raw < NCH ? raw : raw - NCH.
  - Latch inject_en = ({1'b0,p} < cfg_prob) and latch cfg_mode.
  - Clear the timeout counter, then go to DELAY.
- **DELAY:**
  - Count dly cycles; dly=0 means DELAY lasts 1 cycle.
  - At the end: go to INJECT if inject_en, else RUN.
- **INJECT:** exactly one cycle.
  - inj_valid=1 with inj_chan, inj_mask and inj_mode stable during that cycle.
  - For modes 00/01/10, inj_mask = 1<<bit; for mode 11, inj_mask is all ones.
  - Then go to RUN.
- **RUN:** wait for done or timeout.
- **Timeout counter:**
  - Counts every cycle in DELAY, INJECT and RUN.
  - Timeout fires when the count reaches TIMEOUT-1 without done.
  - done and timeout in the same cycle: done wins.
- **done in DELAY:** injection is cancelled; result 00. done is sampled in all three states (DELAY, INJECT, RUN).
- **done in INJECT:** the strobe is still issued; result 01.
- **Result:**
  - On leaving the DELAY/INJECT/RUN group, pulse result_valid for one cycle.
  - result_code = 10 on timeout; else 01 if an injection was issued; else 00.
  - Increment exp_count in the same cycle; go to DUTRST.
- **DUTRST:**
  - dut_rst=1 for RST_CYCLES cycles.
  - Then go to FINISH if exp_count == NEXP, else ARMED with dut_rst=0.
  - ARMED ignores a trigger still high from the previous run until the trigger has been seen low at least once.
- **FINISH:**
  - dut_rst=1, campaign_done=1.
  - start → ARMED with exp_count cleared; the LFSR is not reseeded.
- **start** is ignored in all states other than IDLE and FINISH.

Test Plan:
1. cfg_prob=0, NEXP=3, DUT model asserts done 50 cycles after trigger → 3 result_valid strobes, all code 00; inj_valid never asserts; exp_count=3; campaign_done=1; dut_rst high for 3 cycles after each result.
2. cfg_prob=256, cfg_mode=00, SEED=1 → exactly one inj_valid per experiment, at trigger+dly+1. inj_mask is one-hot and matches the reference-model LFSR; inj_chan < 7; codes 01.
3. cfg_prob=256, TIMEOUT=200, DUT never asserts done → code 10 at cycle 200 after trigger; DUT reset is then pulsed and the next experiment arms.
4. done asserted 1 cycle after trigger while dly > 1 → no inj_valid; code 00. done asserted coincident with the INJECT cycle → inj_valid is still seen; code 01.
5. cfg_mode=11 → inj_mask=32'hFFFFFFFF. rst asserted during RUN → all outputs return to reset values next cycle; no result_valid.
6. Trigger held high across DUTRST → no re-arm until trigger falls and rises again. start during RUN → ignored.
